// File: rtl/rf_dump_streamer.sv
// rf_dump_streamer
//   Debug streamer. Walks the register file through a spare combinational read
//   port and emits every register as bytes, MSB byte first, on a valid/ready
//   byte stream. Each register takes one READ cycle and then BPW SEND beats.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      begin a dump (sampled only in IDLE)
//   busy       dump in progress (READ/SEND)
//   done       one-cycle pulse after the final byte handshake
//   rf_ra      register file read address (rf_rd returns combinationally)
//   rf_rd      register file read data
//   out_data   stream byte
//   out_valid  out_data valid
//   out_ready  sink accepts byte
//   out_last   final byte of the dump
module rf_dump_streamer #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_rd,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);

  localparam int BPW = DW / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [AW-1:0] LAST_A = AW'(NREGS - 1);
  localparam logic [BW-1:0] LAST_B = BW'(BPW - 1);

  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [BW-1:0] byte_idx;
  logic [DW-1:0] shreg;
  logic [DW-1:0] sh_next;
  logic          hs;

  // The shift register keeps the next byte to present in its top 8 bits.
  assign sh_next = shreg << 8;
  assign hs      = (state == SEND) && out_valid && out_ready;
  assign rf_ra   = addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            addr  <= '0;
            busy  <= 1'b1;
          end
        end

        READ: begin
          // rf_rd reflects addr this cycle; latch it so later register-file
          // writes cannot disturb bytes already being sent.
          shreg     <= rf_rd;
          out_data  <= rf_rd[DW-1 -: 8];
          out_valid <= 1'b1;
          out_last  <= (addr == LAST_A) && (LAST_B == '0);
          byte_idx  <= '0;
          state     <= SEND;
        end

        SEND: begin
          // Without a handshake every output simply holds.
          if (hs) begin
            if (byte_idx != LAST_B) begin
              shreg    <= sh_next;
              out_data <= sh_next[DW-1 -: 8];
              byte_idx <= byte_idx + 1'b1;
              out_last <= (addr == LAST_A) && ((byte_idx + 1'b1) == LAST_B);
            end else begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              if (addr == LAST_A) begin
                state <= FIN;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                addr  <= addr + 1'b1;
                state <= READ;
              end
            end
          end
        end

        FIN: begin
          // start is deliberately ignored here; next accept is in IDLE.
          addr  <= '0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
